// File: rtl/datapath_pkg.sv
// rtl/datapath_pkg.sv - opcodes, functs, ALU operations, register indices and encoders
package datapath_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_MUL = 6'b011000;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_V0   = 5'd2;
    localparam logic [4:0] REG_T0   = 5'd8;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT,
        ALU_MUL
    } alu_op_t;

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] funct);
        return {OP_RTYPE, rs, rt, rd, 5'd0, funct};
    endfunction

    function automatic logic [31:0] enc_j(input logic [25:0] target);
        return {OP_J, target};
    endfunction

endpackage

// File: rtl/datapath_alu.sv
// rtl/datapath_alu.sv - combinational 32-bit ALU with zero flag
module datapath_alu
    import datapath_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  alu_op_t     op,
    output logic [31:0] y,
    output logic        zero
);

    // Operation select; all arithmetic wraps mod 2^32
    always_comb begin
        y = 32'd0;
        case (op)
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_SLT: y = {31'd0, ($signed(a) < $signed(b))};
            ALU_MUL: y = a * b;
            default: y = 32'd0;
        endcase
    end

    assign zero = (y == 32'd0);

endmodule

// File: rtl/datapath.sv
// rtl/datapath.sv - single-cycle MIPS-subset core with factorial ROM (optional DATAPATH_HALT_EN)
module datapath
    import datapath_pkg::*;
#(
    parameter int FACT_N     = 5,
    parameter int DMEM_WORDS = 32
)
(
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] result,
    output logic [7:0]  pc,
    output logic [5:0]  opcode
`ifdef DATAPATH_HALT_EN
    ,
    output logic        halted
`endif
);

    localparam int DM_AW = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;

    logic [31:0] instr;
    logic [4:0]  rs, rt, rd;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [31:0] simm;
    logic [31:0] regs [32];
    logic [31:0] dmem [DMEM_WORDS];
    logic [31:0] rs_val, rt_val, alu_b, alu_y, wb, dmem_rdata;
    logic        alu_zero;
    alu_op_t     alu_op;
    logic        alu_src_imm, reg_write, mem_read, mem_write, is_beq, is_bne, jump;
    logic [4:0]  wr_idx;
    logic [DM_AW-1:0] dm_idx;
    logic [7:0]  pc_plus4, next_pc;
    logic        branch_taken;
    logic        unused_shamt;

    // Instruction ROM: the factorial program, all other words execute as NOP
    always_comb begin
        instr = 32'd0;
        case (pc[7:2])
            6'd0: instr = enc_i(OP_ADDI, REG_ZERO, REG_T0, 16'(FACT_N));
            6'd1: instr = enc_i(OP_ADDI, REG_ZERO, REG_V0, 16'd1);
            6'd2: instr = enc_i(OP_BEQ, REG_T0, REG_ZERO, 16'd3);
            6'd3: instr = enc_r(REG_V0, REG_T0, REG_V0, FN_MUL);
            6'd4: instr = enc_i(OP_ADDI, REG_T0, REG_T0, 16'hFFFF);
            6'd5: instr = enc_j(26'd2);
            6'd6: instr = enc_i(OP_SW, REG_ZERO, REG_V0, 16'd0);
            6'd7: instr = enc_j(26'd7);
            default: instr = 32'd0;
        endcase
    end

    assign opcode       = instr[31:26];
    assign rs           = instr[25:21];
    assign rt           = instr[20:16];
    assign rd           = instr[15:11];
    assign funct        = instr[5:0];
    assign imm          = instr[15:0];
    assign simm         = {{16{imm[15]}}, imm};
    assign unused_shamt = ^instr[10:6];

    assign rs_val = regs[rs];
    assign rt_val = regs[rt];

    // Decode: ALU op, operand source, write-back and memory strobes
    always_comb begin
        alu_op      = ALU_ADD;
        alu_src_imm = 1'b0;
        reg_write   = 1'b0;
        wr_idx      = rd;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        is_beq      = 1'b0;
        is_bne      = 1'b0;
        jump        = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                reg_write = 1'b1;
                case (funct)
                    FN_ADD:  alu_op = ALU_ADD;
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_SLT:  alu_op = ALU_SLT;
                    FN_MUL:  alu_op = ALU_MUL;
                    default: reg_write = 1'b0;
                endcase
            end
            OP_ADDI: begin
                alu_src_imm = 1'b1;
                reg_write   = 1'b1;
                wr_idx      = rt;
            end
            OP_LW: begin
                alu_src_imm = 1'b1;
                reg_write   = 1'b1;
                wr_idx      = rt;
                mem_read    = 1'b1;
            end
            OP_SW: begin
                alu_src_imm = 1'b1;
                mem_write   = 1'b1;
            end
            OP_BEQ: begin
                alu_op = ALU_SUB;
                is_beq = 1'b1;
            end
            OP_BNE: begin
                alu_op = ALU_SUB;
                is_bne = 1'b1;
            end
            OP_J:    jump = 1'b1;
            default: ;
        endcase
    end

    assign alu_b = alu_src_imm ? simm : rt_val;

    datapath_alu u_alu (
        .a    (rs_val),
        .b    (alu_b),
        .op   (alu_op),
        .y    (alu_y),
        .zero (alu_zero)
    );

    assign dm_idx     = DM_AW'(32'(alu_y[6:2]) % 32'(DMEM_WORDS));
    assign dmem_rdata = dmem[dm_idx];
    assign wb         = mem_read ? dmem_rdata : alu_y;
    assign result     = reg_write ? wb : 32'd0;

    assign branch_taken = (is_beq & alu_zero) | (is_bne & ~alu_zero);
    assign pc_plus4     = pc + 8'd4;

    // Next-PC select: jump, taken branch, or sequential
    always_comb begin
        next_pc = pc_plus4;
        if (jump)
            next_pc = {instr[5:0], 2'b00};
        else if (branch_taken)
            next_pc = pc_plus4 + {imm[5:0], 2'b00};
    end

    // Program counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pc <= 8'd0;
        else
            pc <= next_pc;
    end

    // Register file; $zero never takes a write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++)
                regs[5'(i)] <= 32'd0;
        end else if (reg_write && (wr_idx != REG_ZERO)) begin
            regs[wr_idx] <= wb;
        end
    end

    // Data RAM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DMEM_WORDS; i++)
                dmem[DM_AW'(i)] <= 32'd0;
        end else if (mem_write) begin
            dmem[dm_idx] <= rt_val;
        end
    end

`ifdef DATAPATH_HALT_EN
    logic self_jump;
    logic halt_flag;

    assign self_jump = jump && ({instr[5:0], 2'b00} == pc);
    assign halted    = self_jump | halt_flag;

    // Sticky halt flag, set by the edge that executes a self-jump
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            halt_flag <= 1'b0;
        else if (self_jump)
            halt_flag <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_datapath.sv
// tb/tb_datapath.sv - scoreboard bench: three factorial cores against a program-level model
module tb_datapath;

    localparam int NA = 5;
    localparam int NB = 0;
    localparam int NC = 13;

    typedef struct {
        logic [7:0]  pc;
        logic [5:0]  op;
        logic [31:0] res;
        logic        halt;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic [2:0][31:0] res;
    logic [2:0][7:0]  pcs;
    logic [2:0][5:0]  ops;
    logic [2:0]       hlt;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    datapath #(.FACT_N(NA)) dut_a (
        .clk(clk), .rst(rst), .result(res[0]), .pc(pcs[0]), .opcode(ops[0])
`ifdef DATAPATH_HALT_EN
        , .halted(hlt[0])
`endif
    );
    datapath #(.FACT_N(NB)) dut_b (
        .clk(clk), .rst(rst), .result(res[1]), .pc(pcs[1]), .opcode(ops[1])
`ifdef DATAPATH_HALT_EN
        , .halted(hlt[1])
`endif
    );
    datapath #(.FACT_N(NC)) dut_c (
        .clk(clk), .rst(rst), .result(res[2]), .pc(pcs[2]), .opcode(ops[2])
`ifdef DATAPATH_HALT_EN
        , .halted(hlt[2])
`endif
    );

`ifndef DATAPATH_HALT_EN
    assign hlt = 3'b000;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic check_one(input int d, input exp_t e);
        chk($sformatf("dut%0d pc", d), 32'(pcs[d]), 32'(e.pc));
        chk($sformatf("dut%0d opcode @pc %0h", d, e.pc), 32'(ops[d]), 32'(e.op));
        chk($sformatf("dut%0d result @pc %0h", d, e.pc), res[d], e.res);
`ifdef DATAPATH_HALT_EN
        chk($sformatf("dut%0d halted @pc %0h", d, e.pc), 32'(hlt[d]), 32'(e.halt));
`endif
    endtask

    // Program-level model of the factorial routine: one trace entry per retired instruction
    task automatic build(input int d, input logic [31:0] nf, input int n);
        exp_t t[$];
        logic [31:0] acc;
        logic [31:0] cnt;
        bit done;
        acc  = 32'd1;
        cnt  = nf;
        done = 1'b0;
        t.push_back('{8'h00, 6'b001000, nf, 1'b0});
        t.push_back('{8'h04, 6'b001000, 32'd1, 1'b0});
        while (t.size() < n + 1) begin
            t.push_back('{8'h08, 6'b000100, 32'd0, 1'b0});
            if (cnt == 0) begin
                done = 1'b1;
                break;
            end
            acc = acc * cnt;
            t.push_back('{8'h0C, 6'b000000, acc, 1'b0});
            cnt = cnt - 1;
            t.push_back('{8'h10, 6'b001000, cnt, 1'b0});
            t.push_back('{8'h14, 6'b000010, 32'd0, 1'b0});
        end
        if (done) begin
            t.push_back('{8'h18, 6'b101011, 32'd0, 1'b0});
            while (t.size() < n + 1)
                t.push_back('{8'h1C, 6'b000010, 32'd0, 1'b1});
        end
        while (t.size() > n + 1)
            void'(t.pop_back());
        foreach (t[i]) begin
            case (d)
                0:       q0.push_back(t[i]);
                1:       q1.push_back(t[i]);
                default: q2.push_back(t[i]);
            endcase
        end
    endtask

    // Monitor: compare each core against the head of its expected trace
    always @(negedge clk) begin
        if (q0.size() > 0) check_one(0, q0.pop_front());
        if (q1.size() > 0) check_one(1, q1.pop_front());
        if (q2.size() > 0) check_one(2, q2.pop_front());
    end

    function automatic bit pending();
        return (q0.size() != 0) || (q1.size() != 0) || (q2.size() != 0);
    endfunction

    // Release reset, run n edges, leave time just after a negedge
    task automatic run(input int n);
        int waited;
        @(posedge clk);
        #2;
        build(0, NA, n);
        build(1, NB, n);
        build(2, NC, n);
        rst = 1'b0;
        waited = 0;
        while (pending() && waited < n + 8) begin
            @(negedge clk);
            #1;
            waited++;
        end
        tests++;
        if (pending()) begin
            fails++;
            $display("FAIL run timeout: %0d entries left, expected 0", q0.size() + q1.size() + q2.size());
            q0.delete();
            q1.delete();
            q2.delete();
        end
    endtask

    // Assert reset between clock edges and check the state cleared without a clock
    task automatic reset_now();
        rst = 1'b1;
        #1;
        chk("async rst pc a", 32'(pcs[0]), 32'd0);
        chk("async rst pc c", 32'(pcs[2]), 32'd0);
        chk("async rst v0", dut_a.regs[2], 32'd0);
        chk("async rst t0", dut_a.regs[8], 32'd0);
        chk("async rst dmem0", dut_a.dmem[0], 32'd0);
        chk("async rst result a", res[0], 32'(NA));
        chk("async rst opcode a", 32'(ops[0]), 32'b001000);
        chk("async rst halted", 32'(hlt), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);

        run(60 + int'($urandom_range(0, 20)));
        chk("dmem0 fact5", dut_a.dmem[0], 32'd120);
        chk("dmem0 fact0", dut_b.dmem[0], 32'd1);
        chk("dmem0 fact13", dut_c.dmem[0], 32'd1932053504);
        reset_now();

        run(10);
        reset_now();

        for (int k = 0; k < 4; k++) begin
            run(int'($urandom_range(3, 40)));
            reset_now();
        end

        run(30 + int'($urandom_range(0, 10)));
        chk("rerun dmem0 fact5", dut_a.dmem[0], 32'd120);
        chk("rerun dmem0 fact0", dut_b.dmem[0], 32'd1);
        reset_now();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
